// File: rtl/debounce_sync.sv
//------------------------------------------------------------------------------
// Module   : debounce_sync
// Purpose  : Conditions a raw asynchronous 1-bit input. Two-stage synchroniser
//            into the clock domain, then a consecutive-sample stability counter
//            that flips the debounced level only after STABLE_CYCLES matching
//            deviating samples. Emits one-cycle rise/fall event pulses.
// Ports    : clock  - single clock, rising edge
//            reset  - synchronous, active-low
//            din    - raw asynchronous input
//            dout   - debounced registered level
//            rise   - one-cycle pulse on dout 0->1
//            fall   - one-cycle pulse on dout 1->0
//            busy   - a candidate change is being counted
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module debounce_sync #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int c_CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W:0] c_TARGET = (c_CNT_W + 1)'(STABLE_CYCLES);

    // The FSM state is implied by the counter value.
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    logic               s1_q;
    logic               s2_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;
    logic               dout_q;
    logic               dout_d;
    logic               rise_q;
    logic               rise_d;
    logic               fall_q;
    logic               fall_d;
    logic [c_CNT_W:0]   w_cnt_inc;
    state_t             w_state;

    // One extra bit so cnt+1 never wraps before the compare.
    assign w_cnt_inc = {1'b0, cnt_q} + 1'b1;
    assign w_state   = (cnt_q != '0) ? ST_COUNTING : ST_IDLE;

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= din;
            s2_q   <= s1_q;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    always_comb begin
        cnt_d  = '0;
        dout_d = dout_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q != dout_q) begin
            if (w_cnt_inc == c_TARGET) begin
                // Enough consecutive deviating samples: commit the new level.
                dout_d = s2_q;
                rise_d = s2_q;
                fall_d = ~s2_q;
            end else begin
                cnt_d = w_cnt_inc[c_CNT_W-1:0];
            end
        end
        // A sample matching dout leaves cnt_d at zero, discarding any
        // partial count so bounces never accumulate.
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (w_state == ST_COUNTING);

endmodule

`default_nettype wire
